// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolve queue.
// Contents:
//   GHR_W_DEF / IDX_W_DEF : default global-history and PHT-index widths
//   PC_INC                : fall-through increment for a not-taken branch
//   FLUSH_NONE / FLUSH_MISPRED : pipeline flush encodings (bit 1 = flush IF/ID/EX)
//   brq_state_e           : recovery FSM states
package bp_pkg;

   localparam int GHR_W_DEF = 3;
   localparam int IDX_W_DEF = 3;

   localparam logic [31:0] PC_INC = 32'd4;

   localparam logic [1:0] FLUSH_NONE    = 2'b00;
   localparam logic [1:0] FLUSH_MISPRED = 2'b10;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } brq_state_e;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Bus bundle between the pipeline (master) and the branch resolve queue (slave).
// Push group  : push_valid, push_idx, push_pred_taken, push_target, push_pc, push_ghr
// Resolve group: resolve_valid, resolve_taken, resolve_target
// Status      : full, underflow_err, count
// Update      : upd_valid, upd_idx, upd_taken
// Redirect    : mispredict, redirect_pc, ghr_restore, flush
interface branch_resolve_queue_if #(
   parameter int GHR_W = 3,
   parameter int IDX_W = 3,
   parameter int CNT_W = 3
);
   logic             push_valid;
   logic [IDX_W-1:0] push_idx;
   logic             push_pred_taken;
   logic [31:0]      push_target;
   logic [31:0]      push_pc;
   logic [GHR_W-1:0] push_ghr;

   logic             resolve_valid;
   logic             resolve_taken;
   logic [31:0]      resolve_target;

   logic             full;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_taken;
   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic [GHR_W-1:0] ghr_restore;
   logic [1:0]       flush;
   logic             underflow_err;
   logic [CNT_W-1:0] count;

   modport master (
      output push_valid, push_idx, push_pred_taken, push_target, push_pc, push_ghr,
      output resolve_valid, resolve_taken, resolve_target,
      input  full, upd_valid, upd_idx, upd_taken, mispredict, redirect_pc,
      input  ghr_restore, flush, underflow_err, count
   );

   modport slave (
      input  push_valid, push_idx, push_pred_taken, push_target, push_pc, push_ghr,
      input  resolve_valid, resolve_taken, resolve_target,
      output full, upd_valid, upd_idx, upd_taken, mispredict, redirect_pc,
      output ghr_restore, flush, underflow_err, count
   );

endinterface

// File: rtl/brq_entry_fifo.sv
// Circular buffer of in-flight branch entries.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   push, pop   : enqueue wr_data / dequeue head; both may be set together
//   clear       : drop every entry (rd_ptr jumps to wr_ptr); overrides push/pop
//   wr_data     : entry to enqueue
//   head_data   : oldest entry (combinational from storage)
//   count       : occupancy, 0..DEPTH
// The caller guarantees push is only raised when a slot is (or is being) freed.
module brq_entry_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [W-1:0]     wr_data,
   output logic [W-1:0]     head_data,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Storage carries no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker for conditional branches between prediction and resolution.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of branch_resolve_queue_if (push, resolve, update,
//           redirect and status signals)
// A resolve is checked against the oldest entry. Every meaningful resolve
// produces a registered predictor update one cycle later; a mispredict also
// produces a one-cycle redirect/flush, empties the queue and parks the FSM in
// RECOVER for one cycle during which pushes and resolves are ignored.
module branch_resolve_queue
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GHR_W = GHR_W_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   branch_resolve_queue_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENT_W = IDX_W + 1 + 32 + 32 + GHR_W;

   // Entry layout, MSB first: {idx, pred_taken, target, pc, ghr}
   localparam int OFS_PC     = GHR_W;
   localparam int OFS_TARGET = GHR_W + 32;
   localparam int OFS_PRED   = GHR_W + 64;
   localparam int OFS_IDX    = GHR_W + 65;

   brq_state_e state_q, state_d;

   logic [ENT_W-1:0] wr_entry;
   logic [ENT_W-1:0] head_entry;
   logic [CNT_W-1:0] fifo_count;

   logic [IDX_W-1:0] head_idx;
   logic             head_pred;
   logic [31:0]      head_target;
   logic [31:0]      head_pc;
   logic [GHR_W-1:0] head_ghr;

   logic in_run;
   logic q_empty;
   logic q_full;
   logic res_ok;
   logic mispredict_now;
   logic do_push;
   logic do_pop;
   logic [31:0] correct_pc;

   logic             upd_valid_q, upd_valid_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic             upd_taken_q, upd_taken_d;
   logic             mispredict_q, mispredict_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;
   logic [GHR_W-1:0] ghr_restore_q, ghr_restore_d;
   logic [1:0]       flush_q, flush_d;
   logic             underflow_q, underflow_d;

   assign wr_entry = {bus.push_idx, bus.push_pred_taken, bus.push_target,
                      bus.push_pc, bus.push_ghr};

   assign head_ghr    = head_entry[GHR_W-1:0];
   assign head_pc     = head_entry[OFS_PC +: 32];
   assign head_target = head_entry[OFS_TARGET +: 32];
   assign head_pred   = head_entry[OFS_PRED];
   assign head_idx    = head_entry[OFS_IDX +: IDX_W];

   brq_entry_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (do_push),
      .pop       (do_pop),
      .clear     (mispredict_now),
      .wr_data   (wr_entry),
      .head_data (head_entry),
      .count     (fifo_count)
   );

   // Resolve compare and queue control
   always_comb begin
      q_empty = (fifo_count == '0);
      q_full  = (fifo_count == CNT_W'(DEPTH));
      res_ok  = bus.resolve_valid && !q_empty && in_run;
      mispredict_now = res_ok &&
                       ((bus.resolve_taken != head_pred) ||
                        (bus.resolve_taken && head_pred &&
                         (bus.resolve_target != head_target)));
      do_pop  = res_ok && !mispredict_now;
      // A same-cycle pop frees the slot, so a full queue can still accept.
      do_push = bus.push_valid && in_run && !mispredict_now && (!q_full || do_pop);
      correct_pc = bus.resolve_taken ? bus.resolve_target : (head_pc + PC_INC);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:     if (mispredict_now) state_d = ST_RECOVER;
         ST_RECOVER: state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_run   = (state_q == ST_RUN);
      bus.full = q_full || (state_q == ST_RECOVER);
   end

   // Registered update / redirect outputs
   always_comb begin
      upd_valid_d   = res_ok;
      upd_idx_d     = res_ok ? head_idx : upd_idx_q;
      upd_taken_d   = res_ok ? bus.resolve_taken : upd_taken_q;
      mispredict_d  = mispredict_now;
      redirect_pc_d = mispredict_now ? correct_pc : 32'd0;
      // Restored history is the snapshot shifted left with the real outcome.
      ghr_restore_d = mispredict_now ? ((head_ghr << 1) | GHR_W'(bus.resolve_taken))
                                     : '0;
      flush_d       = mispredict_now ? FLUSH_MISPRED : FLUSH_NONE;
      // Resolves during RECOVER are ignored and never count as underflow.
      underflow_d   = underflow_q || (bus.resolve_valid && in_run && q_empty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_valid_q   <= 1'b0;
         upd_idx_q     <= '0;
         upd_taken_q   <= 1'b0;
         mispredict_q  <= 1'b0;
         redirect_pc_q <= 32'd0;
         ghr_restore_q <= '0;
         flush_q       <= FLUSH_NONE;
         underflow_q   <= 1'b0;
      end else begin
         upd_valid_q   <= upd_valid_d;
         upd_idx_q     <= upd_idx_d;
         upd_taken_q   <= upd_taken_d;
         mispredict_q  <= mispredict_d;
         redirect_pc_q <= redirect_pc_d;
         ghr_restore_q <= ghr_restore_d;
         flush_q       <= flush_d;
         underflow_q   <= underflow_d;
      end
   end

   assign bus.upd_valid     = upd_valid_q;
   assign bus.upd_idx       = upd_idx_q;
   assign bus.upd_taken     = upd_taken_q;
   assign bus.mispredict    = mispredict_q;
   assign bus.redirect_pc   = redirect_pc_q;
   assign bus.ghr_restore   = ghr_restore_q;
   assign bus.flush         = flush_q;
   assign bus.underflow_err = underflow_q;
   assign bus.count         = fifo_count;

endmodule
